// File: rtl/rf_read_port_if.sv
// Decode/array-facing bundle of the register-file read sequencer: request, response,
// word-line enables, bitline buses and the array write strobe used for bypass.
interface rf_read_port_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_src1;
    logic [3:0]  req_src2;
    logic [15:0] rd_en1;
    logic [15:0] rd_en2;
    logic [15:0] bitline1;
    logic [15:0] bitline2;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data1;
    logic [15:0] rsp_data2;

    modport slave (
        input  req_valid, req_src1, req_src2, bitline1, bitline2,
               wr_en, wr_reg, wr_data, rsp_ready,
        output req_ready, rd_en1, rd_en2, rsp_valid, rsp_data1, rsp_data2
    );

    modport master (
        output req_valid, req_src1, req_src2, bitline1, bitline2,
               wr_en, wr_reg, wr_data, rsp_ready,
        input  req_ready, rd_en1, rd_en2, rsp_valid, rsp_data1, rsp_data2
    );
endinterface

// File: rtl/rf_read_port.sv
// Two-source read sequencer for the 16x16 register array: accept -> one READ cycle -> HOLD.
// Response valid two cycles after accept; a held response blocks new requests until consumed.
module rf_read_port (
    input  logic            clk,
    input  logic            rst,
    rf_read_port_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        capture;
    logic        ready;
    logic [3:0]  src1_q;
    logic [3:0]  src2_q;
    logic [15:0] rd_en1_q;
    logic [15:0] rd_en2_q;
    logic [15:0] data1_q;
    logic [15:0] data2_q;
    logic        valid_q;

    // R0 reads as zero; a write landing on the capture edge wins over the stale bitline.
    function automatic logic [15:0] resolve(
        input logic [3:0]  src,
        input logic [15:0] bitline,
        input logic        wr_en,
        input logic [3:0]  wr_reg,
        input logic [15:0] wr_data
    );
        if (src == 4'd0)
            return 16'h0000;
        else if (wr_en && (wr_reg == src))
            return wr_data;
        else
            return bitline;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                capture   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                ready = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    if (bus.req_valid) begin
                        accept    = 1'b1;
                        state_nxt = READ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Enables are registered off the accept edge so they are live for exactly the READ cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src1_q   <= 4'd0;
            src2_q   <= 4'd0;
            rd_en1_q <= 16'h0000;
            rd_en2_q <= 16'h0000;
            data1_q  <= 16'h0000;
            data2_q  <= 16'h0000;
            valid_q  <= 1'b0;
        end else begin
            rd_en1_q <= accept ? (16'd1 << bus.req_src1) : 16'h0000;
            rd_en2_q <= accept ? (16'd1 << bus.req_src2) : 16'h0000;
            if (accept) begin
                src1_q <= bus.req_src1;
                src2_q <= bus.req_src2;
            end
            if (capture) begin
                data1_q <= resolve(src1_q, bus.bitline1, bus.wr_en, bus.wr_reg, bus.wr_data);
                data2_q <= resolve(src2_q, bus.bitline2, bus.wr_en, bus.wr_reg, bus.wr_data);
                valid_q <= 1'b1;
            end else if ((state == HOLD) && bus.rsp_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rd_en1    = rd_en1_q;
    assign bus.rd_en2    = rd_en2_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_data1 = data1_q;
    assign bus.rsp_data2 = data2_q;
endmodule

// File: tb/tb_rf_read_port.sv
// Bench for rf_read_port: behavioural register array on the bitlines, register-level
// reference model of every response, directed cases followed by randomized traffic.
module tb_rf_read_port;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_read_port_if bus ();

    rf_read_port u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Register array: bitlines carry the enabled word, garbage when no enable is driven.
    logic [15:0] mem [16];
    bit          force_bl = 1'b0;

    always @(posedge clk)
        if (bus.wr_en) mem[bus.wr_reg] <= bus.wr_data;

    always_comb begin
        bus.bitline1 = 16'h0000;
        bus.bitline2 = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (bus.rd_en1[i]) bus.bitline1 = bus.bitline1 | mem[i];
            if (bus.rd_en2[i]) bus.bitline2 = bus.bitline2 | mem[i];
        end
        if (bus.rd_en1 == 16'h0000) bus.bitline1 = 16'hDEAD;
        if (bus.rd_en2 == 16'h0000) bus.bitline2 = 16'hDEAD;
        if (force_bl) begin
            bus.bitline1 = 16'hFFFF;
            bus.bitline2 = 16'hFFFF;
        end
    end

    // Reference: a request accepted at edge N returns the register contents after edge N+1.
    logic [15:0] shadow [16];
    bit          pend;
    logic [3:0]  p1, p2;
    logic [31:0] expq [$];
    bit          held;
    logic [15:0] h1, h2;
    int          n_rsp = 0;

    function automatic logic [15:0] model_rd(input logic [3:0] s);
        return (s == 4'd0) ? 16'h0000 : shadow[s];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend = 1'b0;
            held = 1'b0;
            expq.delete();
        end else begin
            if (held) begin
                check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
                check("hold_data1", {16'd0, bus.rsp_data1}, {16'd0, h1});
                check("hold_data2", {16'd0, bus.rsp_data2}, {16'd0, h2});
            end
            held = bus.rsp_valid && !bus.rsp_ready;
            h1   = bus.rsp_data1;
            h2   = bus.rsp_data2;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (expq.size() == 0) begin
                    check("rsp_spurious", 32'd1, 32'd0);
                end else begin
                    check("rsp_data", {bus.rsp_data1, bus.rsp_data2}, expq.pop_front());
                    n_rsp++;
                end
            end
            if (bus.wr_en) shadow[bus.wr_reg] = bus.wr_data;
            if (pend) begin
                expq.push_back({model_rd(p1), model_rd(p2)});
                pend = 1'b0;
            end
            if (bus.req_valid && bus.req_ready) begin
                pend = 1'b1;
                p1   = bus.req_src1;
                p2   = bus.req_src2;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("en1_onehot", {31'd0, $countones(bus.rd_en1) <= 1}, 32'd1);
            check("en2_onehot", {31'd0, $countones(bus.rd_en2) <= 1}, 32'd1);
            check("en1_model", {16'd0, bus.rd_en1}, pend ? (32'd1 << p1) : 32'd0);
            check("en2_model", {16'd0, bus.rd_en2}, pend ? (32'd1 << p2) : 32'd0);
            check("valid_model", {31'd0, bus.rsp_valid}, {31'd0, expq.size() != 0});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] r, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_reg  = r;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic request(input logic [3:0] s1, input logic [3:0] s2);
        bus.req_valid = 1'b1;
        bus.req_src1  = s1;
        bus.req_src2  = s2;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int acc, cyc, rsp_base;
        bit go;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_src1  = 4'd0;
        bus.req_src2  = 4'd0;
        bus.wr_en     = 1'b0;
        bus.wr_reg    = 4'd0;
        bus.wr_data   = 16'h0000;
        bus.rsp_ready = 1'b0;
        #2 rst = 1'b1;
        #2;
        check("rst_en1", {16'd0, bus.rd_en1}, 32'd0);
        check("rst_en2", {16'd0, bus.rd_en2}, 32'd0);
        check("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_data", {bus.rsp_data1, bus.rsp_data2}, 32'd0);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        step();
        rst = 1'b0;

        for (int r = 0; r < 16; r++) write_reg(4'(r), 16'($urandom));
        write_reg(4'd3, 16'h1234);
        write_reg(4'd7, 16'hBEEF);
        write_reg(4'd2, 16'h2222);
        write_reg(4'd5, 16'h0001);

        // basic read
        request(4'd3, 4'd7);
        check("t1_en1", {16'd0, bus.rd_en1}, 32'h0008);
        check("t1_en2", {16'd0, bus.rd_en2}, 32'h0080);
        check("t1_ready_read", {31'd0, bus.req_ready}, 32'd0);
        step();
        check("t1_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("t1_data", {bus.rsp_data1, bus.rsp_data2}, 32'h1234BEEF);
        check("t1_en_hold", {bus.rd_en1, bus.rd_en2}, 32'd0);
        consume();
        check("t1_valid_after", {31'd0, bus.rsp_valid}, 32'd0);

        // R0 with bitlines forced high
        force_bl = 1'b1;
        request(4'd0, 4'd0);
        check("t2_en", {bus.rd_en1, bus.rd_en2}, 32'h00010001);
        step();
        force_bl = 1'b0;
        check("t2_data", {bus.rsp_data1, bus.rsp_data2}, 32'h0);
        consume();

        // write bypass on the capture edge
        request(4'd5, 4'd2);
        bus.wr_en   = 1'b1;
        bus.wr_reg  = 4'd5;
        bus.wr_data = 16'hA5A5;
        check("t3_old_bitline", {16'd0, bus.bitline1}, 32'h0001);
        step();
        bus.wr_en = 1'b0;
        check("t3_bypass", {bus.rsp_data1, bus.rsp_data2}, 32'hA5A52222);
        consume();
        request(4'd0, 4'd5);
        bus.wr_en   = 1'b1;
        bus.wr_reg  = 4'd0;
        bus.wr_data = 16'hFFFF;
        step();
        bus.wr_en = 1'b0;
        check("t3_r0_write", {bus.rsp_data1, bus.rsp_data2}, 32'h0000A5A5);
        consume();

        // response stall with a waiting request
        request(4'd7, 4'd3);
        step();
        bus.req_valid = 1'b1;
        bus.req_src1  = 4'd7;
        bus.req_src2  = 4'd2;
        for (int i = 0; i < 5; i++) begin
            check("t4_ready_stall", {31'd0, bus.req_ready}, 32'd0);
            check("t4_data_stable", {bus.rsp_data1, bus.rsp_data2}, 32'hBEEF1234);
            check("t4_en_zero", {bus.rd_en1, bus.rd_en2}, 32'd0);
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("t4_ready_pass", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check("t4_next_en", {bus.rd_en1, bus.rd_en2}, 32'h00800004);
        check("t4_next_valid", {31'd0, bus.rsp_valid}, 32'd0);
        step();
        check("t4_next_data", {bus.rsp_data1, bus.rsp_data2}, 32'hBEEF2222);
        consume();

        // reset during READ
        request(4'd3, 4'd7);
        rst = 1'b1;
        #1;
        check("t5_en", {bus.rd_en1, bus.rd_en2}, 32'd0);
        check("t5_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("t5_data", {bus.rsp_data1, bus.rsp_data2}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end

        // randomized traffic
        acc      = 0;
        cyc      = 0;
        rsp_base = n_rsp;
        while (acc < 1000 && cyc < 20000) begin
            bus.wr_en     = 1'($urandom_range(0, 1));
            bus.wr_reg    = 4'($urandom);
            bus.wr_data   = 16'($urandom);
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            if (!bus.req_valid) bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_src1  = 4'($urandom);
            bus.req_src2  = ($urandom_range(0, 7) == 0) ? bus.req_src1 : 4'($urandom);
            #1;
            go = bus.req_valid && bus.req_ready;
            if (go) acc++;
            @(posedge clk); #1;
            cyc++;
            if (go) bus.req_valid = 1'b0;
        end
        if (acc < 1000) check("rand_budget", acc, 32'd1000);
        bus.req_valid = 1'b0;
        bus.wr_en     = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (4) step();
        check("rand_drain", expq.size(), 32'd0);
        check("rand_rsp_count", n_rsp - rsp_base, 32'd1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rf_read_port.md
# rf_read_port

Read-side sequencer for the 16×16 register file built from bit-cell registers. Accepts a two-source read request, drives one-hot read-enable word lines onto the array, samples the two shared bitline buses, applies same-cycle write bypass and the R0-is-zero rule, and holds the result under a valid/ready handshake. Sits between decode and the register array; it is the counterpart that owns the ReadEnable1/ReadEnable2 lines every register consumes.

## Interface
- No parameters: 16 registers, 16-bit data, 4-bit register IDs.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  read request present
- req_ready  out  1  request accepted when req_valid && req_ready at rising edge
- req_src1, req_src2  in  4 each  source register IDs
- rd_en1, rd_en2  out  16 each  one-hot read enables to registers 0..15 (port 1 / port 2)
- bitline1, bitline2  in  16 each  array read buses, valid only while the matching enable is asserted
- wr_en  in  1  array write strobe (same signal the array uses)
- wr_reg  in  4  register being written
- wr_data  in  16  data being written
- rsp_valid  out  1  read data held
- rsp_ready  in  1  consumer takes data when rsp_valid && rsp_ready at rising edge
- rsp_data1, rsp_data2  out  16 each  read results

## Operation
- FSM states: IDLE, READ, HOLD. Reset state IDLE.
- IDLE: req_ready=1. On accept, latch src1/src2 → READ.
- READ (exactly one cycle): rd_en1 = 1<<src1, rd_en2 = 1<<src2; all other enable bits 0; req_ready=0. At end of cycle capture into rsp_data1/2 → HOLD.
- Capture value per port, priority order: src==0 → 16'h0000 (R0 never sampled; its enable bit still driven); else wr_en && wr_reg==src → wr_data (bypass: array updates on the same edge, bitline still shows old value); else bitline.
- Both ports may name the same register; each resolves independently and identically.
- HOLD: rsp_valid=1, rsp_data stable. req_ready = rsp_ready. On rsp_ready: if req_valid also high, accept new request → READ; else → IDLE.
- Writes during IDLE/HOLD do not alter held data (snapshot at READ edge); a write on the accept edge is visible because READ occurs after it.
- rd_en1/rd_en2 are 16'h0000 in every state other than READ (no bitline contention/drive outside READ).
- req_src changes while not accepted are ignored.

## Timing
- Reset (async, immediate): state IDLE, rd_en1=rd_en2=0, rsp_valid=0, rsp_data1=rsp_data2=0, req_ready=1 once rst deasserts.
- Accept at edge N → READ during cycle N+1 → rsp_valid high from N+2.
- Back-to-back throughput: one request per 2 cycles with rsp_ready held high.
- rsp_valid, rsp_data, rd_en are registered outputs; req_ready is combinational from state and rsp_ready only.
- rst asserted during READ or HOLD: request dropped, no response, enables cleared in same cycle.
- rsp_valid never deasserts without a handshake except by reset.

## Test plan
- After reset, array R3=16'h1234, R7=16'hBEEF; request (3,7) → rd_en1=16'h0008, rd_en2=16'h0080 for one cycle, rsp_data1=16'h1234, rsp_data2=16'hBEEF two cycles after accept.
- Request (0,0) with bitlines forced 16'hFFFF → both outputs 16'h0000; rd_en1=rd_en2=16'h0001 during READ.
- During READ, wr_en=1, wr_reg=5, wr_data=16'hA5A5, request (5,2), bitline1 shows old 16'h0001 → rsp_data1=16'hA5A5, rsp_data2=bitline2; wr_reg=0 write → rsp 0.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 → req_ready=0, rsp_data stable, rd_en all zero; then rsp_ready=1 → new request accepted same edge, next READ follows.
- Assert rst mid-READ → rd_en, rsp_valid, rsp_data go 0 immediately; no response appears after rst drops.
- Random 1000 requests with random writes and rsp_ready stalls vs. reference register model → every response matches, enables always one-hot or zero.
